range_monitor_real: RTL and testbench
=====================================

RANGE_MONITOR_REAL -- requirements
Module: range_monitor_real

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the signed fixed-point input code.
REQ-002 Parameter EXPONENT, default -8, binary exponent of the input; value = code * 2^EXPONENT, used only for reporting.
REQ-003 Parameter LIMIT, default 16384, permitted magnitude in input LSBs; legal range -LIMIT..+LIMIT inclusive; 0 < LIMIT < 2^(WIDTH-1).
REQ-004 Parameter WINDOW, default 1024, number of accepted samples per measurement window; WINDOW >= 1.
REQ-005 Parameter CNT_W, default 16, width of the sample and violation counters; 2^CNT_W > WINDOW.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; synchronous, active-low.
REQ-008 start  input  1  one-cycle pulse that opens a window.
REQ-009 clear  input  1  one-cycle pulse that returns the block to IDLE with results zeroed.
REQ-010 in_valid  input  1  qualifies in for the current cycle.
REQ-011 in  input  WIDTH  signed fixed-point sample.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.
REQ-014 min_out / max_out  output  WIDTH each  signed extremes of accepted samples in the current or last window.
REQ-015 viol_count  output  CNT_W  number of accepted out-of-range samples, saturating at 2^CNT_W-1.
REQ-016 viol  output  1  sticky flag, set on the first out-of-range sample.
REQ-017 first_viol_idx  output  CNT_W  zero-based index within the window of the first violating sample.

Function
REQ-018 States are IDLE, RUN and DONE, encoded internally; busy = (RUN), done = (DONE).
REQ-019 IDLE -> RUN on start; RUN -> DONE on the cycle the WINDOW-th sample is accepted; DONE -> RUN on start; any state -> IDLE on clear.
REQ-020 clear has priority over start and in_valid in the same cycle.
REQ-021 On entry to RUN, on the same edge: sample counter = 0, viol_count = 0, viol = 0, first_viol_idx = 0, min_out = +(2^(WIDTH-1)-1), max_out = -(2^(WIDTH-1)).
REQ-022 A sample is accepted only when state is RUN and in_valid = 1; samples arriving in IDLE or DONE are ignored.
REQ-023 start while already in RUN is ignored; the window continues.
REQ-024 start and in_valid in the same cycle from IDLE or DONE open the window; that sample is not accepted.
REQ-025 On acceptance, min_out/max_out update by signed compare with one-cycle latency; equal values leave them unchanged.
REQ-026 Violation: in < -LIMIT or in > +LIMIT, signed; exactly +-LIMIT is legal.
REQ-027 On a violating accepted sample, viol_count increments (saturating), viol sets; if viol was 0, first_viol_idx captures the current sample counter value.
REQ-028 The sample counter increments per accepted sample; it never wraps within a window because DONE is entered at WINDOW.
REQ-029 The last accepted sample of a window updates min/max/viol outputs on the same edge that enters DONE.
REQ-030 In DONE all result outputs hold until start or clear.
REQ-031 clear zeroes viol_count, viol, first_viol_idx, min_out and max_out.
REQ-032 All outputs are registered; no combinational path from input to output.

Reset
REQ-033 With rst = 0 at a rising edge: state = IDLE, busy = 0, done = 0, viol = 0, viol_count = 0, first_viol_idx = 0, min_out = 0, max_out = 0, sample counter = 0.
REQ-034 Reset asserted mid-window aborts the window; after release the block waits in IDLE for start.
REQ-035 Reset has priority over clear and start.

Verification
REQ-036 Defaults. Reset, start, then 4 valid samples 100, -200, 50, 16384 (WINDOW=4) -> done = 1 the cycle after the 4th; min_out = -200, max_out = 16384, viol = 0, viol_count = 0.
REQ-037 Violations. WINDOW=4; samples 0, 16385, -16385, 5 -> viol = 1, viol_count = 2, first_viol_idx = 1, min_out = -16385, max_out = 16385.
REQ-038 Gaps and ignore. in_valid toggled 1,0,1,0... during RUN; samples with valid = 0 and samples sent in DONE -> no effect on counters or extremes.
REQ-039 Priority. clear and start asserted together in RUN -> IDLE next cycle, outputs zeroed; start in RUN alone -> window continues, counter not reset.
REQ-040 Saturation. CNT_W=4, WINDOW=15, every sample 32767 -> viol_count = 15, done = 1; CNT_W=4 with WINDOW=15 and all samples violating does not wrap.
REQ-041 Reset mid-window. rst = 0 after 2 of 4 samples -> all outputs at reset values next edge; a new start then runs a full 4-sample window correctly.

Source files
------------

// File: rtl/range_monitor_real.sv
`default_nettype none
// ============================================================================
//  Module      : range_monitor_real
//  Description : Windowed range monitor for a signed fixed-point stream.
//                Over a window of WINDOW accepted samples it tracks the signed
//                minimum and maximum, counts samples outside -LIMIT..+LIMIT,
//                and records the index of the first violating sample.
//  Ports       : clk            - clock, all state changes on rising edge
//                rst            - synchronous reset, active low
//                start          - opens a window (from IDLE or DONE)
//                clear          - returns to IDLE with results zeroed
//                in_valid / in  - sample qualifier and signed sample code
//                busy / done    - window running / window complete
//                min_out/max_out- signed extremes of accepted samples
//                viol_count     - saturating count of out-of-range samples
//                viol           - sticky out-of-range flag
//                first_viol_idx - window index of the first violation
//  Revision    : 1.0 - initial release
// ============================================================================
module range_monitor_real #(
    parameter int WIDTH    = 16,
    parameter int EXPONENT = -8,     // value = code * 2^EXPONENT, reporting only
    parameter int LIMIT    = 16384,
    parameter int WINDOW   = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] min_out,
    output logic signed [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0]        viol_count,
    output logic                    viol,
    output logic [CNT_W-1:0]        first_viol_idx
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if ((LIMIT <= 0) || (LIMIT >= (2 ** (WIDTH - 1)))) begin : g_bad_limit
        $error("range_monitor_real: LIMIT out of range");
    end
    if ((WINDOW < 1) || ((2 ** CNT_W) <= WINDOW)) begin : g_bad_window
        $error("range_monitor_real: WINDOW must be >= 1 and < 2^CNT_W");
    end
    if ((EXPONENT < -1024) || (EXPONENT > 1024)) begin : g_bad_exponent
        $error("range_monitor_real: EXPONENT implausible");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic signed [WIDTH-1:0] c_pos_lim = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] c_neg_lim = -c_pos_lim;
    // Extremes are seeded with the opposite rail so the first sample wins.
    localparam logic signed [WIDTH-1:0] c_most_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]        c_last_idx = CNT_W'(WINDOW - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        r_sample_cnt;
    logic signed [WIDTH-1:0] r_min;
    logic signed [WIDTH-1:0] r_max;
    logic [CNT_W-1:0]        r_viol_cnt;
    logic                    r_viol;
    logic [CNT_W-1:0]        r_first_idx;

    logic w_accept;
    logic w_open;
    logic w_last;
    logic w_out_of_range;

    assign w_accept       = (r_state == c_run) && in_valid;
    // A start in RUN is ignored; from IDLE or DONE it opens a fresh window.
    assign w_open         = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last         = w_accept && (r_sample_cnt == c_last_idx);
    assign w_out_of_range = (in > c_pos_lim) || (in < c_neg_lim);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle:  if (start)  w_state_nxt = c_run;
                c_run:   if (w_last) w_state_nxt = c_done;
                c_done:  if (start)  w_state_nxt = c_run;
                default: w_state_nxt = c_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_idle;
            r_sample_cnt <= '0;
            r_min        <= '0;
            r_max        <= '0;
            r_viol_cnt   <= '0;
            r_viol       <= 1'b0;
            r_first_idx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_sample_cnt <= '0;
                r_min        <= '0;
                r_max        <= '0;
                r_viol_cnt   <= '0;
                r_viol       <= 1'b0;
                r_first_idx  <= '0;
            end else if (w_open) begin
                // A sample presented with the opening start is not accepted.
                r_sample_cnt <= '0;
                r_min        <= c_most_pos;
                r_max        <= c_most_neg;
                r_viol_cnt   <= '0;
                r_viol       <= 1'b0;
                r_first_idx  <= '0;
            end else if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
                if (in < r_min) r_min <= in;
                if (in > r_max) r_max <= in;
                if (w_out_of_range) begin
                    r_viol <= 1'b1;
                    if (r_viol_cnt != {CNT_W{1'b1}}) r_viol_cnt <= r_viol_cnt + 1'b1;
                    if (!r_viol) r_first_idx <= r_sample_cnt;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all sourced directly from registers)
    // ------------------------------------------------------------------------
    assign busy           = (r_state == c_run);
    assign done           = (r_state == c_done);
    assign min_out        = r_min;
    assign max_out        = r_max;
    assign viol_count     = r_viol_cnt;
    assign viol           = r_viol;
    assign first_viol_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_range_monitor_real.sv
`default_nettype none
// ============================================================================
//  Module      : tb_range_monitor_real
//  Description : Self-checking bench for range_monitor_real. Instance A uses
//                WINDOW=4 with default width/limit; instance B uses CNT_W=4,
//                WINDOW=15 for the saturation corner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_range_monitor_real;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic               rst_a, start_a, clear_a, vld_a;
    logic signed [15:0] in_a;
    logic               busy_a, done_a, viol_a;
    logic signed [15:0] min_a, max_a;
    logic [15:0]        cnt_a, idx_a;

    range_monitor_real #(
        .WIDTH(16), .EXPONENT(-8), .LIMIT(16384), .WINDOW(4), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .clear(clear_a),
        .in_valid(vld_a), .in(in_a), .busy(busy_a), .done(done_a),
        .min_out(min_a), .max_out(max_a), .viol_count(cnt_a),
        .viol(viol_a), .first_viol_idx(idx_a)
    );

    // ---------------- instance B ----------------
    logic               rst_b, start_b, clear_b, vld_b;
    logic signed [15:0] in_b;
    logic               busy_b, done_b, viol_b;
    logic signed [15:0] min_b, max_b;
    logic [3:0]         cnt_b, idx_b;

    range_monitor_real #(
        .WIDTH(16), .EXPONENT(-8), .LIMIT(16384), .WINDOW(15), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .clear(clear_b),
        .in_valid(vld_b), .in(in_b), .busy(busy_b), .done(done_b),
        .min_out(min_b), .max_out(max_b), .viol_count(cnt_b),
        .viol(viol_b), .first_viol_idx(idx_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse_a;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
    endtask

    task automatic feed_a(input logic signed [15:0] s);
        vld_a = 1'b1;
        in_a  = s;
        tick;
        vld_a = 1'b0;
    endtask

    task automatic check_results_a(input string tag, input logic signed [15:0] emin,
                                   input logic signed [15:0] emax, input logic ev,
                                   input int ecnt, input int eidx);
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_min"},  min_a,  emin);
        chk({tag, "_max"},  max_a,  emax);
        chk({tag, "_viol"}, viol_a, ev);
        chk({tag, "_cnt"},  cnt_a,  ecnt);
        chk({tag, "_idx"},  idx_a,  eidx);
    endtask

    // Reference: results of a window from the list of accepted samples.
    logic signed [15:0] acc_q[$];

    task automatic check_model_a(input string tag);
        logic signed [15:0] emin;
        logic signed [15:0] emax;
        logic               ev;
        int                 ecnt;
        int                 eidx;
        emin = 16'sd32767;
        emax = -16'sd32768;
        ev   = 1'b0;
        ecnt = 0;
        eidx = 0;
        for (int k = 0; k < acc_q.size(); k++) begin
            if (acc_q[k] < emin) emin = acc_q[k];
            if (acc_q[k] > emax) emax = acc_q[k];
            if ((int'(acc_q[k]) > 16384) || (int'(acc_q[k]) < -16384)) begin
                if (!ev) eidx = k;
                ev = 1'b1;
                ecnt++;
            end
        end
        check_results_a(tag, emin, emax, ev, ecnt, eidx);
    endtask

    typedef struct {
        logic signed [15:0] s [4];
        logic signed [15:0] emin;
        logic signed [15:0] emax;
        logic               ev;
        int                 ecnt;
        int                 eidx;
    } vec_t;

    vec_t vt [4];

    function automatic logic signed [15:0] pick_sample;
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return 16'($urandom);
            1:       return 16'(16384 + int'($urandom_range(0, 4)) - 2);
            2:       return 16'(-16384 + int'($urandom_range(0, 4)) - 2);
            default: return 16'(int'($urandom_range(0, 200)) - 100);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;

        vt[0].s = '{16'sd100, -16'sd200, 16'sd50, 16'sd16384};
        vt[0].emin = -16'sd200;   vt[0].emax = 16'sd16384; vt[0].ev = 1'b0; vt[0].ecnt = 0; vt[0].eidx = 0;
        vt[1].s = '{16'sd0, 16'sd16385, -16'sd16385, 16'sd5};
        vt[1].emin = -16'sd16385; vt[1].emax = 16'sd16385; vt[1].ev = 1'b1; vt[1].ecnt = 2; vt[1].eidx = 1;
        vt[2].s = '{-16'sd16384, -16'sd16384, 16'sd16384, -16'sd16385};
        vt[2].emin = -16'sd16385; vt[2].emax = 16'sd16384; vt[2].ev = 1'b1; vt[2].ecnt = 1; vt[2].eidx = 3;
        vt[3].s = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        vt[3].emin = 16'sd7;      vt[3].emax = 16'sd7;     vt[3].ev = 1'b0; vt[3].ecnt = 0; vt[3].eidx = 0;

        rst_a = 1'b0; start_a = 1'b0; clear_a = 1'b0; vld_a = 1'b0; in_a = '0;
        rst_b = 1'b0; start_b = 1'b0; clear_b = 1'b0; vld_b = 1'b0; in_b = '0;
        tick;
        tick;

        // ---------------- reset state ----------------
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_min",  min_a,  0);
        chk("rst_max",  max_a,  0);
        chk("rst_viol", viol_a, 0);
        chk("rst_cnt",  cnt_a,  0);
        chk("rst_idx",  idx_a,  0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick;

        // ---------------- table-driven windows ----------------
        for (int i = 0; i < 4; i++) begin
            start_pulse_a;
            chk($sformatf("tbl%0d_open_busy", i), busy_a, 1);
            chk($sformatf("tbl%0d_open_min", i),  min_a,  32767);
            chk($sformatf("tbl%0d_open_max", i),  max_a,  -32768);
            for (int j = 0; j < 4; j++) begin
                feed_a(vt[i].s[j]);
                if (j == 2) chk($sformatf("tbl%0d_not_done", i), done_a, 0);
            end
            check_results_a($sformatf("tbl%0d", i), vt[i].emin, vt[i].emax,
                            vt[i].ev, vt[i].ecnt, vt[i].eidx);
        end

        // ---------------- gaps and ignored samples ----------------
        start_pulse_a;
        feed_a(16'sd10);
        in_a = 16'sd30000;  tick;
        feed_a(-16'sd5);
        in_a = -16'sd30000; tick;
        feed_a(16'sd20);
        in_a = 16'sd32767;  tick;
        feed_a(16'sd3);
        check_results_a("gap", -16'sd5, 16'sd20, 1'b0, 0, 0);
        feed_a(16'sd30000);
        feed_a(-16'sd30000);
        check_results_a("done_hold", -16'sd5, 16'sd20, 1'b0, 0, 0);

        // ---------------- start+in_valid opening from DONE ----------------
        start_a = 1'b1; vld_a = 1'b1; in_a = -16'sd30000;
        tick;
        start_a = 1'b0; vld_a = 1'b0;
        chk("open_vld_busy", busy_a, 1);
        chk("open_vld_min",  min_a,  32767);
        chk("open_vld_viol", viol_a, 0);
        feed_a(16'sd1);
        feed_a(16'sd2);
        feed_a(16'sd3);
        chk("open_vld_not_done", done_a, 0);
        feed_a(16'sd4);
        check_results_a("open_vld", 16'sd1, 16'sd4, 1'b0, 0, 0);

        // ---------------- start in RUN ignored ----------------
        start_pulse_a;
        feed_a(16'sd20000);
        feed_a(16'sd1);
        start_pulse_a;
        chk("run_start_busy", busy_a, 1);
        chk("run_start_cnt",  cnt_a,  1);
        feed_a(-16'sd2);
        feed_a(16'sd6);
        check_results_a("run_start", -16'sd2, 16'sd20000, 1'b1, 1, 0);

        // ---------------- clear beats start ----------------
        start_pulse_a;
        feed_a(16'sd20000);
        clear_a = 1'b1; start_a = 1'b1; vld_a = 1'b1; in_a = -16'sd20000;
        tick;
        clear_a = 1'b0; start_a = 1'b0; vld_a = 1'b0;
        chk("clr_busy", busy_a, 0);
        chk("clr_done", done_a, 0);
        chk("clr_min",  min_a,  0);
        chk("clr_max",  max_a,  0);
        chk("clr_viol", viol_a, 0);
        chk("clr_cnt",  cnt_a,  0);
        feed_a(16'sd99);
        chk("idle_ignore_min", min_a, 0);

        // ---------------- reset mid-window ----------------
        start_pulse_a;
        feed_a(16'sd100);
        feed_a(16'sd20000);
        rst_a = 1'b0;
        tick;
        chk("mrst_busy", busy_a, 0);
        chk("mrst_min",  min_a,  0);
        chk("mrst_max",  max_a,  0);
        chk("mrst_viol", viol_a, 0);
        chk("mrst_cnt",  cnt_a,  0);
        chk("mrst_idx",  idx_a,  0);
        rst_a = 1'b1;
        feed_a(-16'sd300);
        chk("mrst_idle_busy", busy_a, 0);
        start_pulse_a;
        for (int j = 0; j < 4; j++) feed_a(vt[1].s[j]);
        check_results_a("mrst_rerun", vt[1].emin, vt[1].emax, vt[1].ev, vt[1].ecnt, vt[1].eidx);

        // ---------------- saturation on instance B ----------------
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        vld_b = 1'b1;
        in_b  = 16'sd32767;
        for (int j = 0; j < 14; j++) tick;
        chk("sat14_done", done_b, 0);
        chk("sat14_cnt",  cnt_b,  14);
        tick;
        vld_b = 1'b0;
        chk("sat_done", done_b, 1);
        chk("sat_cnt",  cnt_b,  15);
        chk("sat_viol", viol_b, 1);
        chk("sat_idx",  idx_b,  0);
        chk("sat_max",  max_b,  32767);

        // ---------------- randomized windows vs model ----------------
        for (int w = 0; w < 25; w++) begin
            start_pulse_a;
            acc_q.delete();
            cycles = 0;
            while ((acc_q.size() < 4) && (cycles < 100)) begin
                vld_a   = 1'($urandom_range(0, 1));
                in_a    = pick_sample();
                start_a = ($urandom_range(0, 9) == 0);
                tick;
                if (vld_a) acc_q.push_back(in_a);
                cycles++;
            end
            vld_a   = 1'b0;
            start_a = 1'b0;
            chk($sformatf("rnd%0d_accepted", w), acc_q.size(), 4);
            check_model_a($sformatf("rnd%0d", w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
